// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_t   : controller phase (IDLE, LO half-word, HI half-word, DONE)
//   BASE_ADDR : default byte address mapped to SRAM word 0
//   SRAM_DW   : SRAM data width (half-word)
//   SRAM_AW   : default SRAM address width (half-word granularity)
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW   = 16;
  localparam int          SRAM_AW   = 18;

endpackage

// File: rtl/wait_counter.sv
// Wait-state timer for one half-word SRAM phase.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : synchronous clear (asserted on every phase entry)
//   en   : count enable (asserted while a phase is in progress)
//   done : high while the count equals WAIT_CYCLES-1 (last cycle of a phase)
module wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: performs one 32-bit load/store as two half-word
// accesses on an external 16-bit asynchronous SRAM, stalling the pipeline
// through ready while busy.
// Ports:
//   clk, rst      : system clock, asynchronous active-low reset
//   mem_r_en      : load request
//   mem_w_en      : store request (wins over load if both set)
//   addr          : byte address, addr[1:0] ignored
//   st_val        : store data
//   ready         : 0 while an access is pending or in progress
//   rd_data       : last completed load result
//   sram_addr     : half-word address to the SRAM
//   sram_dq_out   : write data to the pad
//   sram_dq_oe    : 1 = controller drives DQ
//   sram_dq_in    : read data from the pad
//   sram_we_n     : active-low write strobe
//
// state | meaning
// IDLE  | waiting for a request; latches op/address/data on request
// LO    | low half-word on the bus for WAIT_CYCLES cycles
// HI    | high half-word on the bus for WAIT_CYCLES cycles
// DONE  | access complete, ready=1, pipeline advances on this edge
module mem_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = arm_mem_pkg::BASE_ADDR,
  parameter int          SRAM_AW     = arm_mem_pkg::SRAM_AW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_r_en,
  input  logic                             mem_w_en,
  input  logic [31:0]                      addr,
  input  logic [31:0]                      st_val,
  output logic                             ready,
  output logic [31:0]                      rd_data,
  output logic [SRAM_AW-1:0]               sram_addr,
  output logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_out,
  output logic                             sram_dq_oe,
  input  logic [arm_mem_pkg::SRAM_DW-1:0]  sram_dq_in,
  output logic                             sram_we_n
);

  import arm_mem_pkg::*;

  localparam int WIDX_W = SRAM_AW - 1;

  state_t              state;
  logic                wr_op;
  logic [WIDX_W-1:0]   widx_q;
  logic [SRAM_DW-1:0]  st_hi_q;
  logic [WIDX_W-1:0]   widx;
  logic                req;
  logic                phase_done;
  logic                cnt_en;
  logic                cnt_clr;

  assign req = mem_r_en | mem_w_en;

  // Addresses below BASE_ADDR wrap modulo 2^32 before truncation.
  assign widx = WIDX_W'((addr - BASE_ADDR) >> 2);

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign cnt_en  = (state == LO) || (state == HI);
  // Clear on every state entry so each phase starts counting from zero.
  assign cnt_clr = ((state == IDLE) && req) || (cnt_en && phase_done) || (state == DONE);

  wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .done (phase_done)
  );

  // Bus outputs are loaded at phase entry from latched values, so they stay
  // stable for the whole phase regardless of upstream input changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_op       <= 1'b0;
      widx_q      <= '0;
      st_hi_q     <= '0;
      rd_data     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LO;
            wr_op       <= mem_w_en;
            widx_q      <= widx;
            st_hi_q     <= st_val[31:16];
            sram_addr   <= {widx, 1'b0};
            sram_dq_out <= st_val[15:0];
            sram_dq_oe  <= mem_w_en;
            sram_we_n   <= ~mem_w_en;
          end
        end
        LO: begin
          if (phase_done) begin
            state       <= HI;
            sram_addr   <= {widx_q, 1'b1};
            sram_dq_out <= st_hi_q;
            if (!wr_op) rd_data[15:0] <= sram_dq_in;
          end
        end
        HI: begin
          if (phase_done) begin
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!wr_op) rd_data[31:16] <= sram_dq_in;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed vector table, hand-written
// corner sequences (back-to-back, reset mid-access, WAIT_CYCLES=1) and a
// randomized run checked against a word-level memory model.
module tb_mem_sram_ctrl;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT with WAIT_CYCLES = 2
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] st_val = '0;
  logic        ready;
  logic [31:0] rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  mem_sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .st_val(st_val), .ready(ready), .rd_data(rd_data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  // DUT with WAIT_CYCLES = 1 (read latency corner)
  logic        r1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic        ready1;
  logic [31:0] rd1;
  logic [17:0] sa1;
  logic [15:0] dqo1;
  logic        oe1;
  logic [15:0] dqi1;
  logic        we1;

  mem_sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(1'b0),
    .addr(addr1), .st_val(32'h0), .ready(ready1), .rd_data(rd1),
    .sram_addr(sa1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
    .sram_dq_in(dqi1), .sram_we_n(we1)
  );

  assign dqi1 = (sa1 == 18'd2) ? 16'h1234 : (sa1 == 18'd3) ? 16'hABCD : 16'h0000;

  // Asynchronous SRAM model (256 half-words, address aliased on low bits)
  logic [15:0] sram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [15:0] pre_d = '0;

  always @(negedge clk) begin
    if (pre_we) sram[pre_a] <= pre_d;
    else if (!sram_we_n) sram[sram_addr[7:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram[sram_addr[7:0]];

  // Word-level reference memory for the random run
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_rd_cur;

  int n_chk = 0;
  int n_pass = 0;
  int wr_phases = 0;
  int rd_phases = 0;
  logic [17:0] prev_addr = '0;
  logic        prev_we_n = 1'b1;
  logic [17:0] first_wr_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [17:0] hw_of(input logic [31:0] a);
    logic [31:0] t;
    t = (a - 32'd1024) >> 2;
    return 18'(t << 1);
  endfunction

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
    int stalls = 0;
    int lo_we = 0;
    int hi_we = 0;
    int oe_cyc = 0;
    bit got = 0;
    bit seen_wr = 0;
    @(negedge clk);
    mem_r_en = r; mem_w_en = w; addr = a; st_val = d;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (!sram_we_n && (prev_we_n || sram_addr != prev_addr)) begin
        wr_phases++;
        if (!seen_wr) begin first_wr_addr = sram_addr; seen_wr = 1; end
      end
      if (!ready && sram_we_n && !sram_dq_oe && sram_addr != prev_addr) rd_phases++;
      prev_addr = sram_addr;
      prev_we_n = sram_we_n;
      if (ready) begin got = 1; break; end
      stalls++;
      if (!sram_we_n) begin
        if (sram_addr[0]) hi_we++;
        else lo_we++;
      end
      if (sram_dq_oe) oe_cyc++;
      @(negedge clk); #1;
      // request already latched: drop it and scramble inputs mid-access
      if (i == 0) begin
        mem_r_en = 1'b0; mem_w_en = 1'b0; addr = $urandom; st_val = $urandom;
      end
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_stalls"}, stalls, 2 * W + 1);
    chk({nm, "_rd"}, rd_data, exp_rd);
    chk({nm, "_we_n_done"}, 32'(sram_we_n), 32'd1);
    if (w) begin
      chk({nm, "_lo_we_cycles"}, lo_we, W);
      chk({nm, "_hi_we_cycles"}, hi_we, W);
    end else begin
      chk({nm, "_we_cycles"}, lo_we + hi_we, 0);
      chk({nm, "_oe_cycles"}, oe_cyc, 0);
    end
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] hw;
    logic [7:0]  hwi;
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
    int          op;
    int          stalls;
    int          bus_bad;
    bit          got;

    tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hABCD1234};
    tbl[2] = '{1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 32'hABCD1234};
    tbl[3] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEBABE, 32'hABCD1234};
    tbl[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEBABE};
    tbl[5] = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b1, 32'd1020, 32'h600DCAFE, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h600DCAFE};

    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_bus", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
    end

    preload(8'd2, 16'h1234);
    preload(8'd3, 16'hABCD);

    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, $sformatf("vec%0d", i));
      if (tbl[i].w) begin
        hw = hw_of(tbl[i].a);
        hwi = hw[7:0];
        chk($sformatf("vec%0d_lo_half", i), 32'(sram[hwi]), 32'(tbl[i].d[15:0]));
        hwi = hwi + 8'd1;
        chk($sformatf("vec%0d_hi_half", i), 32'(sram[hwi]), 32'(tbl[i].d[31:16]));
        chk($sformatf("vec%0d_sram_addr", i), 32'(first_wr_addr), 32'(hw));
      end
    end

    // back-to-back store then load of the same word
    wr_phases = 0;
    rd_phases = 0;
    do_access(1'b0, 1'b1, 32'd1040, 32'h13579BDF, 32'h600DCAFE, "b2b_st");
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, 32'h13579BDF, "b2b_ld");
    chk("b2b_wr_phases", wr_phases, 2);
    chk("b2b_rd_phases", rd_phases, 2);
    exp_rd_cur = 32'h13579BDF;

    // random run against the word-level model
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      a = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      ref_mem[k] = d;
      do_access(1'b0, 1'b1, a, d, exp_rd_cur, "rnd_init");
    end
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
      d = $urandom;
      a = 32'd1024 + 32'(4 * idx) + 32'($urandom_range(0, 3));
      if (op == 0) begin
        exp_rd_cur = ref_mem[idx];
        do_access(1'b1, 1'b0, a, d, exp_rd_cur, "rnd_ld");
      end else begin
        ref_mem[idx] = d;
        do_access(op == 2, 1'b1, a, d, exp_rd_cur, "rnd_st");
      end
    end

    // reset asserted during the HI phase of a store
    @(negedge clk);
    mem_w_en = 1'b1; addr = 32'd1060; st_val = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_in_hi", {30'd0, sram_we_n, sram_addr[0]}, 32'b01);
    mem_w_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_rst_addr", 32'(sram_addr), 32'h0);
    chk("mid_rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("mid_rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
    prev_addr = sram_addr;
    prev_we_n = sram_we_n;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, ref_mem[0], "post_rst_ld");

    // WAIT_CYCLES = 1 read: 3 stall cycles
    @(negedge clk);
    r1 = 1'b1; addr1 = 32'd1028;
    #1;
    stalls = 0;
    bus_bad = 0;
    got = 0;
    for (int i = 0; i < 32; i++) begin
      if (ready1) begin got = 1; break; end
      stalls++;
      if (!we1 || oe1) bus_bad++;
      @(negedge clk); #1;
    end
    r1 = 1'b0;
    chk("w1_done", 32'(got), 32'd1);
    chk("w1_stalls", stalls, 3);
    chk("w1_rd", rd1, 32'hABCD1234);
    chk("w1_bus", bus_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
